// File: rtl/dac_spi_tx.sv
// dac_spi_tx: floor-truncates a Q(n-2).2 sample, saturates it to 12-bit offset-binary
// and shifts it MSB-first to an SPI DAC as a {CMD, code} 16-bit frame.
module dac_spi_tx #(
  parameter int          cant_bits = 25,
  parameter int          CLK_DIV   = 4,
  parameter logic [3:0]  CMD       = 4'b0011
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [cant_bits-1:0] dato,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        dac_cs_n,
  output logic                        dac_sclk,
  output logic                        dac_mosi
);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic signed [cant_bits-1:0] SMAX = cant_bits'(2047);
  localparam logic signed [cant_bits-1:0] SMIN = cant_bits'(-2048);
  state_t state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [4:0] half_q, half_d;
  logic [15:0] sh_q, sh_d;
  logic busy_q, busy_d, done_q, done_d, cs_n_q, cs_n_d, sclk_q, sclk_d;
  logic signed [cant_bits-1:0] ent;
  logic [11:0] sat;
  logic wrap;
  always_comb begin
    ent = dato >>> 2;
    sat = ent > SMAX ? 12'h7FF : ent < SMIN ? 12'h800 : ent[11:0];
    wrap = div_q == DIV_LAST;
    state_d = state_q;
    div_d = wrap ? 8'd0 : div_q + 8'd1;
    half_d = half_q;
    sh_d = sh_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cs_n_d = cs_n_q;
    sclk_d = sclk_q;
    case (state_q)
      IDLE: begin
        div_d = 8'd0;
        if (start) begin
          state_d = SETUP;
          sh_d = {CMD, ~sat[11], sat[10:0]};
          busy_d = 1'b1;
          cs_n_d = 1'b0;
          half_d = 5'd0;
        end
      end
      SETUP: if (wrap) begin
        state_d = SHIFT;
        sclk_d = 1'b1;
      end
      SHIFT: if (wrap) begin
        half_d = half_q + 5'd1;
        if (half_q == 5'd31) begin
          state_d = HOLD;
          sclk_d = 1'b0;
          cs_n_d = 1'b1;
          sh_d = 16'd0;
        end else begin
          sclk_d = ~sclk_q;
          // data moves on the falling edge so it is centred on the next rising edge
          sh_d = sclk_q ? {sh_q[14:0], 1'b0} : sh_q;
        end
      end
      HOLD: if (wrap) begin
        state_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q <= 8'd0;
      half_q <= 5'd0;
      sh_q <= 16'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cs_n_q <= 1'b1;
      sclk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      half_q <= half_d;
      sh_q <= sh_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cs_n_q <= cs_n_d;
      sclk_q <= sclk_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign dac_cs_n = cs_n_q;
  assign dac_sclk = sclk_q;
  assign dac_mosi = sh_q[15];
endmodule
